// File: rtl/avr_fetch.sv
// AVR instruction fetch unit: streams 16-bit program words to the core,
// glues two-word opcodes (LDS/STS/JMP/CALL) into one output, absorbs
// consumer stalls with a one-entry skid buffer, and restarts on redirect.
module avr_fetch #(
  parameter int              PC_W      = 16,
  parameter logic [PC_W-1:0] RESET_VEC = '0
) (
  input  logic            CLK,
  input  logic            RST,
  output logic [PC_W-1:0] p_addr,
  output logic            p_rd,
  input  logic [15:0]     p_data,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [15:0]     instr,
  output logic [15:0]     instr_ext,
  output logic [PC_W-1:0] instr_pc,
  output logic            instr_valid
);

  // FILL: nothing to show; RUN: output valid; WAIT_EXT: first word of a
  // two-word opcode parked; HOLD: output stalled with the skid occupied.
  typedef enum logic [1:0] {FILL, RUN, WAIT_EXT, HOLD} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            rd_pend_q, rd_pend_d;
  logic [PC_W-1:0] pend_addr_q, pend_addr_d;
  logic [15:0]     skid_data_q, skid_data_d;
  logic [PC_W-1:0] skid_addr_q, skid_addr_d;
  logic [15:0]     first_word_q, first_word_d;
  logic [PC_W-1:0] first_pc_q, first_pc_d;
  logic [15:0]     instr_q, instr_d;
  logic [15:0]     ext_q, ext_d;
  logic [PC_W-1:0] ipc_q, ipc_d;

  logic            out_valid;
  logic            blocked;
  logic            src_valid;
  logic [15:0]     src_word;
  logic [PC_W-1:0] src_addr;

  // LDS 1001000xxxxx0000, STS 1001001xxxxx0000, JMP/CALL 1001010xxxxx11xx
  function automatic logic is_two_word(input logic [15:0] w);
    return ((w[15:10] == 6'b100100) && (w[3:0] == 4'b0000)) ||
           ((w[15:9] == 7'b1001010) && (w[3:2] == 2'b11));
  endfunction

  // Memory side: issue a read every cycle unless the held output is stalled;
  // a redirect always wins and reads its target in the same cycle.
  always_comb begin
    out_valid   = (state_q == RUN) || (state_q == HOLD);
    blocked     = out_valid && stall;
    p_rd        = !RST && (redirect || !blocked);
    p_addr      = redirect ? redirect_pc : pc_q;
    pc_d        = pc_q;
    if (redirect) begin
      pc_d = redirect_pc + PC_W'(1);
    end else if (p_rd) begin
      pc_d = pc_q + PC_W'(1);
    end
    rd_pend_d   = p_rd;
    pend_addr_d = p_addr;
  end

  // Instruction assembly: pick the next raw word (skid first, then memory),
  // pair up two-word opcodes and load the output register when it may move.
  always_comb begin
    state_d      = state_q;
    skid_data_d  = skid_data_q;
    skid_addr_d  = skid_addr_q;
    first_word_d = first_word_q;
    first_pc_d   = first_pc_q;
    instr_d      = instr_q;
    ext_d        = ext_q;
    ipc_d        = ipc_q;
    src_valid    = (state_q == HOLD) || rd_pend_q;
    src_word     = (state_q == HOLD) ? skid_data_q : p_data;
    src_addr     = (state_q == HOLD) ? skid_addr_q : pend_addr_q;
    if (redirect) begin
      state_d = FILL;
    end else if (blocked) begin
      if ((state_q == RUN) && rd_pend_q) begin
        skid_data_d = p_data;
        skid_addr_d = pend_addr_q;
        state_d     = HOLD;
      end
    end else if (src_valid) begin
      if (state_q == WAIT_EXT) begin
        instr_d = first_word_q;
        ext_d   = src_word;
        ipc_d   = first_pc_q;
        state_d = RUN;
      end else if (is_two_word(src_word)) begin
        first_word_d = src_word;
        first_pc_d   = src_addr;
        state_d      = WAIT_EXT;
      end else begin
        instr_d = src_word;
        ext_d   = 16'h0000;
        ipc_d   = src_addr;
        state_d = RUN;
      end
    end else if (state_q != WAIT_EXT) begin
      state_d = FILL;
    end
  end

  // State register with synchronous reset that drops everything in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= FILL;
      pc_q         <= RESET_VEC;
      rd_pend_q    <= 1'b0;
      pend_addr_q  <= '0;
      skid_data_q  <= 16'h0000;
      skid_addr_q  <= '0;
      first_word_q <= 16'h0000;
      first_pc_q   <= '0;
      instr_q      <= 16'h0000;
      ext_q        <= 16'h0000;
      ipc_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      rd_pend_q    <= rd_pend_d;
      pend_addr_q  <= pend_addr_d;
      skid_data_q  <= skid_data_d;
      skid_addr_q  <= skid_addr_d;
      first_word_q <= first_word_d;
      first_pc_q   <= first_pc_d;
      instr_q      <= instr_d;
      ext_q        <= ext_d;
      ipc_q        <= ipc_d;
    end
  end

  assign instr       = instr_q;
  assign instr_ext   = ext_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = out_valid;

endmodule

// File: tb/tb_avr_fetch.sv
// Directed bench for avr_fetch: a one-cycle-latency program memory model and
// a queue of expected instructions popped whenever the consumer accepts one.
module tb_avr_fetch;

  logic        CLK;
  logic        RST;
  logic [15:0] p_addr;
  logic        p_rd;
  logic [15:0] p_data;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] instr;
  logic [15:0] instr_ext;
  logic [15:0] instr_pc;
  logic        instr_valid;

  typedef struct packed {
    logic [15:0] i;
    logic [15:0] e;
    logic [15:0] pc;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] pmem [0:65535];
  int          total;
  int          passes;
  int          fails;

  avr_fetch dut (
    .CLK         (CLK),
    .RST         (RST),
    .p_addr      (p_addr),
    .p_rd        (p_rd),
    .p_data      (p_data),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .instr_ext   (instr_ext),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Program memory: data for a read strobed in one cycle shows up in the next.
  always @(posedge CLK) p_data <= p_rd ? pmem[p_addr] : 16'hBEEF;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pushExp(input logic [15:0] i, input logic [15:0] e, input logic [15:0] pc);
    exp_t x;
    x.i  = i;
    x.e  = e;
    x.pc = pc;
    sb.push_back(x);
  endtask

  task automatic applyStimulus(input logic rst, input logic st, input logic rd, input logic [15:0] rpc);
    RST         = rst;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
  endtask

  // Compares the output against the scoreboard head mid-cycle; the head is
  // retired only when the consumer takes it (valid and not stalled).
  task automatic checkOutput(input string tag, input bit expValid);
    exp_t x;
    @(negedge CLK);
    checkVal({tag, ".valid"}, 32'(instr_valid), 32'(expValid));
    if (expValid) begin
      checkVal({tag, ".sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        x = sb[0];
        checkVal({tag, ".instr"}, 32'(instr), 32'(x.i));
        checkVal({tag, ".instr_ext"}, 32'(instr_ext), 32'(x.e));
        checkVal({tag, ".instr_pc"}, 32'(instr_pc), 32'(x.pc));
        if (!stall) x = sb.pop_front();
      end
    end
  endtask

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    total  = 0;
    passes = 0;
    fails  = 0;
    for (int i = 0; i < 65536; i++) pmem[i] = 16'(i + 32'h1000);
    pmem[0]    = 16'hE0A4;
    pmem[1]    = 16'h50A1;
    pmem[2]    = 16'h0000;
    pmem[16]   = 16'hE010;
    pmem[32]   = 16'h940C;
    pmem[33]   = 16'h0030;

    // Reset state
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    nextCycle();
    nextCycle();
    checkOutput("rst", 1'b0);
    checkVal("rst.p_rd", 32'(p_rd), 32'd0);
    checkVal("rst.instr", 32'(instr), 32'd0);
    checkVal("rst.instr_ext", 32'(instr_ext), 32'd0);
    checkVal("rst.instr_pc", 32'(instr_pc), 32'd0);
    nextCycle();

    // Straight-line single-word stream after reset
    pushExp(16'hE0A4, 16'h0000, 16'h0000);
    pushExp(16'h50A1, 16'h0000, 16'h0001);
    pushExp(16'h0000, 16'h0000, 16'h0002);
    pushExp(16'h1003, 16'h0000, 16'h0003);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("seq.c0", 1'b0);
    checkVal("seq.c0.p_rd", 32'(p_rd), 32'd1);
    checkVal("seq.c0.p_addr", 32'(p_addr), 32'h0);
    nextCycle();
    checkOutput("seq.c1", 1'b0);
    nextCycle();
    for (int c = 2; c < 6; c++) begin
      checkOutput($sformatf("seq.c%0d", c), 1'b1);
      nextCycle();
    end

    // Two-word JMP followed by a stall of three cycles on 0x50A1
    pmem[0] = 16'h940C;
    pmem[1] = 16'h0010;
    pmem[2] = 16'h50A1;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    @(negedge CLK);
    checkVal("rst2.p_rd", 32'(p_rd), 32'd0);
    nextCycle();
    pushExp(16'h940C, 16'h0010, 16'h0000);
    pushExp(16'h50A1, 16'h0000, 16'h0002);
    pushExp(16'h1003, 16'h0000, 16'h0003);
    pushExp(16'h1004, 16'h0000, 16'h0004);
    pushExp(16'h1005, 16'h0000, 16'h0005);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("jmp.c0", 1'b0);
    nextCycle();
    checkOutput("jmp.c1", 1'b0);
    nextCycle();
    checkOutput("jmp.c2", 1'b0);
    nextCycle();
    checkOutput("jmp.c3", 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    for (int c = 4; c < 7; c++) begin
      checkOutput($sformatf("stall.c%0d", c), 1'b1);
      checkVal($sformatf("stall.c%0d.p_rd", c), 32'(p_rd), 32'd0);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("stall.c7", 1'b1);
    checkVal("stall.c7.p_addr", 32'(p_addr), 32'h4);
    nextCycle();
    checkOutput("stall.c8", 1'b1);
    nextCycle();
    checkOutput("stall.c9", 1'b1);
    nextCycle();

    // Redirect to 0x0010
    pushExp(16'hE010, 16'h0000, 16'h0010);
    pushExp(16'h1011, 16'h0000, 16'h0011);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0010);
    checkOutput("redir.r0", 1'b1);
    checkVal("redir.r0.p_addr", 32'(p_addr), 32'h10);
    checkVal("redir.r0.p_rd", 32'(p_rd), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("redir.r1", 1'b0);
    checkVal("redir.r1.p_addr", 32'(p_addr), 32'h11);
    nextCycle();
    checkOutput("redir.r2", 1'b1);
    nextCycle();

    // Redirect with stall while a JMP waits for its second word
    pushExp(16'hE010, 16'h0000, 16'h0010);
    pushExp(16'h1011, 16'h0000, 16'h0011);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0020);
    checkOutput("wext.s0", 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("wext.s1", 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0010);
    checkOutput("wext.s2", 1'b0);
    checkVal("wext.s2.p_addr", 32'(p_addr), 32'h10);
    checkVal("wext.s2.p_rd", 32'(p_rd), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("wext.s3", 1'b0);
    nextCycle();
    checkOutput("wext.s4", 1'b1);
    nextCycle();

    // Address wrap at 0xFFFF, then reset mid-stream
    pmem[0] = 16'h1000;
    pmem[1] = 16'h1001;
    pmem[2] = 16'h1002;
    pushExp(16'h0FFF, 16'h0000, 16'hFFFF);
    pushExp(16'h1000, 16'h0000, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFF);
    checkOutput("wrap.f0", 1'b1);
    checkVal("wrap.f0.p_addr", 32'(p_addr), 32'hFFFF);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("wrap.f1", 1'b0);
    checkVal("wrap.f1.p_addr", 32'(p_addr), 32'h0000);
    nextCycle();
    checkOutput("wrap.f2", 1'b1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("wrap.f3", 1'b1);
    checkVal("wrap.f3.p_rd", 32'(p_rd), 32'd0);
    nextCycle();
    pushExp(16'h1000, 16'h0000, 16'h0000);
    pushExp(16'h1001, 16'h0000, 16'h0001);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("rst3.c0", 1'b0);
    checkVal("rst3.c0.instr", 32'(instr), 32'd0);
    checkVal("rst3.c0.p_addr", 32'(p_addr), 32'h0);
    checkVal("rst3.c0.p_rd", 32'(p_rd), 32'd1);
    nextCycle();
    checkOutput("rst3.c1", 1'b0);
    nextCycle();
    checkOutput("rst3.c2", 1'b1);
    nextCycle();
    checkOutput("rst3.c3", 1'b1);
    nextCycle();

    checkVal("sb.drained", 32'(sb.size()), 32'd0);
    if (fails == 0) $display("[TB] every comparison matched");
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
